// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcode map, instruction
// field layout and FSM state encoding.
package seq_pkg;

    localparam int unsigned OPC_W     = 4;
    localparam int unsigned OPERAND_W = 12;
    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned OPC_LSB   = 12;
    localparam int unsigned OPC_MSB   = OPC_LSB + OPC_W - 1;

    localparam logic [OPC_W-1:0] OPC_NOP     = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ALU_MIN = 4'h1;
    localparam logic [OPC_W-1:0] OPC_ALU_MAX = 4'h7;
    localparam logic [OPC_W-1:0] OPC_JMP     = 4'h8;
    localparam logic [OPC_W-1:0] OPC_JZ      = 4'h9;
    localparam logic [OPC_W-1:0] OPC_HALT    = 4'hF;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWaitAlu,
        StAdvance,
        StJump,
        StHalt,
        StError
    } seq_state_e;

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction decoder: splits the instruction register into
// opcode class flags, the ALU function and the 12-bit operand.
module seq_decoder
    import seq_pkg::*;
(
    input  logic [15:0]           ir,
    output logic                  is_nop,
    output logic                  is_alu,
    output logic                  is_jmp,
    output logic                  is_jz,
    output logic                  is_halt,
    output logic                  illegal,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [OPERAND_W-1:0]  operand
);

    logic [OPC_W-1:0] opc;

    assign opc     = ir[OPC_MSB:OPC_LSB];
    assign alu_op  = opc[ALU_OP_W-1:0];
    assign operand = ir[OPERAND_W-1:0];

    // Classify the opcode; anything outside the defined map is illegal.
    always_comb begin
        is_nop  = (opc == OPC_NOP);
        is_alu  = (opc >= OPC_ALU_MIN) && (opc <= OPC_ALU_MAX);
        is_jmp  = (opc == OPC_JMP);
        is_jz   = (opc == OPC_JZ);
        is_halt = (opc == OPC_HALT);
        illegal = !(is_nop || is_alu || is_jmp || is_jz || is_halt);
    end

endmodule

// File: rtl/instr_sequencer.sv
// Control FSM of the arithmetic processor: fetch, decode, ALU dispatch and
// PC step/load control. Optional ALU watchdog enabled by defining SEQ_WDOG_EN.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned WDOG_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic [ADDR_W-1:0]    pc_addr,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic [ADDR_W-1:0]    pc_target,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic                 alu_start,
    output logic [2:0]           alu_op,
    output logic [11:0]          alu_operand,
    input  logic                 alu_done,
    input  logic                 alu_zero,
    output logic                 halted,
    output logic                 error
);

    seq_state_e            state_q, state_d;
    logic [INSTR_W-1:0]    ir_q;
    logic                  zero_q;
    logic                  wdog_expired;

    logic                  is_nop, is_alu, is_jmp, is_jz, is_halt, illegal;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic [OPERAND_W-1:0]  dec_operand;

    // PC value is observed only; the PC itself owns wrap-around.
    logic [ADDR_W-1:0]     unused_pc_addr;
    assign unused_pc_addr = pc_addr;

    seq_decoder u_decoder (
        .ir      (ir_q[15:0]),
        .is_nop  (is_nop),
        .is_alu  (is_alu),
        .is_jmp  (is_jmp),
        .is_jz   (is_jz),
        .is_halt (is_halt),
        .illegal (illegal),
        .alu_op  (dec_alu_op),
        .operand (dec_operand)
    );

`ifdef SEQ_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_q;

    // Count WAIT_ALU cycles; cleared in EXEC so each op starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (state_q == StExec) begin
            wdog_q <= '0;
        end else if (state_q == StWaitAlu) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    // wdog_q holds n-1 during the n-th WAIT_ALU cycle.
    assign wdog_expired = (wdog_q == WDOG_W'(WDOG_CYC - 1));
`else
    logic [31:0] unused_wdog_cyc;
    assign unused_wdog_cyc = WDOG_CYC;
    assign wdog_expired    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register and ALU zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q   <= '0;
            zero_q <= 1'b0;
        end else begin
            if (state_q == StFetch && imem_ack) begin
                ir_q <= imem_data;
            end
            if (state_q == StWaitAlu && alu_done) begin
                zero_q <= alu_zero;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (go) state_d = StFetch;
            StFetch:   if (imem_ack) state_d = StDecode;
            StDecode: begin
                if (is_nop)       state_d = StAdvance;
                else if (is_alu)  state_d = StExec;
                else if (is_jmp)  state_d = StJump;
                else if (is_jz)   state_d = zero_q ? StJump : StAdvance;
                else if (is_halt) state_d = StHalt;
                else              state_d = StError;
            end
            StExec:    state_d = StWaitAlu;
            // A done arriving in the timeout cycle takes priority.
            StWaitAlu: begin
                if (alu_done)          state_d = StAdvance;
                else if (wdog_expired) state_d = StError;
            end
            StAdvance: state_d = StFetch;
            StJump:    state_d = StFetch;
            StHalt:    if (go) state_d = StAdvance;
            StError:   state_d = StError;
            default:   state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        imem_req    = (state_q == StFetch);
        alu_start   = (state_q == StExec);
        pc_inc      = (state_q == StAdvance);
        pc_load     = (state_q == StJump);
        halted      = (state_q == StHalt);
        error       = (state_q == StError);
        alu_op      = '0;
        alu_operand = '0;
        pc_target   = '0;
        if (state_q == StExec || state_q == StWaitAlu) begin
            alu_op      = dec_alu_op;
            alu_operand = dec_operand;
        end
        if (state_q == StJump) begin
            pc_target = {{(ADDR_W - OPERAND_W){1'b0}}, dec_operand};
        end
        // illegal is implied by the DECODE fall-through; kept for observability.
        if (illegal && state_q == StIdle) begin
            alu_op = '0;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level model predicts the
// sequence of PC/ALU/halt/error events for each fetched instruction.
module tb_instr_sequencer;

    localparam int unsigned WDOG = 8;
    localparam int SIG_REQ = 0, SIG_ALU = 1, SIG_INC = 2, SIG_HALT = 3, SIG_ERR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [15:0] pc;
    logic        pc_inc, pc_load, imem_req, alu_start, halted, error;
    logic [15:0] pc_target;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [2:0]  alu_op;
    logic [11:0] alu_operand;
    logic        alu_done, alu_zero;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(16), .INSTR_W(16), .WDOG_CYC(WDOG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .pc_addr     (pc),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .alu_done    (alu_done),
        .alu_zero    (alu_zero),
        .halted      (halted),
        .error       (error)
    );

    typedef enum int {EvInc, EvLoad, EvAlu, EvHalt, EvErr} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [15:0] val;
    } ev_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] imem [256];
    logic        zero_m = 1'b0;
    bit          auto_mode = 0;
    bit          alu_hang = 0;
    int          dir_alu_dly = 0;
    bit          dir_alu_zero = 0;
    int          fetches = 0;
    logic [15:0] cur_alu_exp = '0;

    // Program counter partner driven by the sequencer's pulses.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc <= '0;
        else if (pc_load) pc <= pc_target;
        else if (pc_inc)  pc <= pc + 16'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic [15:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got %s 0x%0h want no event", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            chk({"event_", e.kind.name()}, {16'(int'(k)), v}, {16'(int'(e.kind)), e.val});
        end
    endtask

    function automatic void push(input ev_kind_e k, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    // Reference behaviour of one instruction, expressed as its visible events.
    function automatic void issue(input logic [15:0] ins);
        logic [3:0]  opc;
        logic [15:0] opnd;
        opc  = ins[15:12];
        opnd = {4'h0, ins[11:0]};
        if (opc == 4'h0) begin
            push(EvInc, '0);
        end else if (opc <= 4'h7) begin
            cur_alu_exp = {1'b0, opc[2:0], ins[11:0]};
            push(EvAlu, cur_alu_exp);
            push(alu_hang ? EvErr : EvInc, '0);
        end else if (opc == 4'h8) begin
            push(EvLoad, opnd);
        end else if (opc == 4'h9) begin
            if (zero_m) push(EvLoad, opnd);
            else        push(EvInc, '0);
        end else if (opc == 4'hF) begin
            push(EvHalt, '0);
            push(EvInc, '0);
        end else begin
            push(EvErr, '0);
        end
    endfunction

    // Instruction memory responder, with random latency and stray acks in auto mode.
    initial begin
        bit f_active;
        int f_wait;
        f_active  = 0;
        f_wait    = 0;
        imem_ack  = 1'b0;
        imem_data = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (!rst_n) begin
                f_active = 0;
            end else if (imem_req) begin
                if (!f_active) begin
                    f_active = 1;
                    f_wait   = auto_mode ? int'($urandom_range(0, 2)) : 0;
                end
                if (f_wait == 0) begin
                    imem_ack  = 1'b1;
                    imem_data = imem[pc[7:0]];
                    issue(imem_data);
                    f_active  = 0;
                    fetches++;
                end else begin
                    f_wait--;
                    imem_data = 16'($urandom);
                end
            end else if (auto_mode && $urandom_range(0, 7) == 0) begin
                imem_ack  = 1'b1;
                imem_data = 16'($urandom);
            end
        end
    end

    // ALU responder: completes each launched op after a delay, sets the model zero flag.
    initial begin
        bit a_busy;
        int a_cnt;
        bit a_zero;
        a_busy   = 0;
        a_cnt    = 0;
        a_zero   = 0;
        alu_done = 1'b0;
        alu_zero = 1'b0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            alu_zero = 1'b0;
            if (!rst_n) begin
                a_busy = 0;
                zero_m = 1'b0;
            end else if (a_busy) begin
                if (a_cnt == 0) begin
                    chk("alu_hold", {1'b0, alu_op, alu_operand}, cur_alu_exp);
                    alu_done = 1'b1;
                    alu_zero = a_zero;
                    zero_m   = a_zero;
                    a_busy   = 0;
                end else begin
                    a_cnt--;
                end
            end else if (alu_start) begin
                a_busy = !alu_hang;
                a_cnt  = auto_mode ? int'($urandom_range(0, 5)) : dir_alu_dly;
                a_zero = auto_mode ? 1'($urandom_range(0, 1)) : dir_alu_zero;
            end else if (auto_mode && $urandom_range(0, 9) == 0) begin
                alu_done = 1'b1;
                alu_zero = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: every visible event is matched against the scoreboard.
    initial begin
        bit halted_p, error_p;
        halted_p = 0;
        error_p  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                halted_p = 0;
                error_p  = 0;
            end else begin
                if (pc_inc || pc_load) chk("inc_load_exclusive", {63'b0, pc_inc & pc_load}, 0);
                if (pc_inc)    expect_ev(EvInc, '0);
                if (pc_load)   expect_ev(EvLoad, pc_target);
                if (alu_start) expect_ev(EvAlu, {1'b0, alu_op, alu_operand});
                if (halted && !halted_p) expect_ev(EvHalt, '0);
                if (error && !error_p)   expect_ev(EvErr, '0);
                halted_p = halted;
                error_p  = error;
            end
        end
    end

    function automatic bit sig(input int s);
        case (s)
            SIG_REQ:  return imem_req;
            SIG_ALU:  return alu_start;
            SIG_INC:  return pc_inc;
            SIG_HALT: return halted;
            SIG_ERR:  return error;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int s, input int limit, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            go = 1'b0;
            n++;
        end while (!sig(s) && n < limit);
        if (!sig(s)) begin
            total++;
            bad++;
            $display("FAIL %s: got no pulse in %0d cycles want pulse", name, n);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        go    = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) imem[i] = v;
    endtask

    function automatic logic [15:0] rand_instr();
        int r;
        logic [11:0] opnd;
        r    = int'($urandom_range(0, 99));
        opnd = 12'($urandom);
        if (r < 15)      return {4'h0, opnd};
        else if (r < 55) return {4'($urandom_range(1, 7)), opnd};
        else if (r < 65) return {4'h8, opnd};
        else if (r < 80) return {4'h9, opnd};
        else if (r < 92) return {4'hF, opnd};
        else             return {4'($urandom_range(10, 14)), opnd};
    endfunction

    initial begin
        int n;
        bit seen;
        int hwait;

        // Reset in the middle of an ALU wait aborts silently.
        fill_mem(16'hF000);
        imem[0] = 16'h1001;
        dir_alu_dly = 20;
        reset_dut();
        chk("reset_outputs", {pc_inc, pc_load, pc_target, imem_req, alu_start, alu_op,
                              alu_operand, halted, error}, 0);
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_ALU, 10, "t1_alu_start", n);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {pc_inc, pc_load, pc_target, imem_req, alu_start, alu_op,
                              alu_operand, halted, error}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= imem_req | pc_inc | pc_load | alu_start;
        end
        chk("idle_after_abort", {63'b0, seen}, 0);
        go = 1'b1;
        wait_sig(SIG_REQ, 5, "t1_restart", n);
        chk("restart_latency", n, 1);

        // NOP latency and refetch.
        fill_mem(16'hF000);
        imem[0] = 16'h0000;
        reset_dut();
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_INC, 10, "t2_inc", n);
        chk("nop_latency", n, 3);
        @(negedge clk);
        chk("nop_refetch", {63'b0, imem_req}, 1);
        wait_sig(SIG_HALT, 10, "t2_halt", n);

        // ALU op followed by a taken JZ.
        fill_mem(16'hF000);
        imem[0] = 16'h3005;
        imem[1] = 16'h9123;
        dir_alu_dly  = 4;
        dir_alu_zero = 1;
        reset_dut();
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_HALT, 40, "t3_halt", n);
        chk("jz_taken_pc", pc, 16'h0123);

        // JZ not taken after a non-zero ALU result.
        imem[0] = 16'h2001;
        imem[1] = 16'h9050;
        dir_alu_zero = 0;
        reset_dut();
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_HALT, 40, "t3b_halt", n);
        chk("jz_not_taken_pc", pc, 16'h0002);

        // JMP to the top of the operand range, HALT there, resume.
        fill_mem(16'hF000);
        imem[0]    = 16'h8FFF;
        imem[8'hFF] = 16'hF000;
        reset_dut();
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_HALT, 20, "t4_halt", n);
        chk("jmp_pc", pc, 16'h0FFF);
        repeat (3) @(negedge clk);
        chk("halt_held", {63'b0, halted}, 1);
        go = 1'b1;
        wait_sig(SIG_INC, 5, "t4_resume", n);
        chk("resume_latency", n, 1);
        wait_sig(SIG_REQ, 5, "t4_refetch", n);
        chk("resume_pc", pc, 16'h1000);

        // Illegal opcode is terminal; go is ignored.
        fill_mem(16'hF000);
        imem[0] = 16'hA000;
        reset_dut();
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_ERR, 20, "t5_error", n);
        repeat (3) begin
            @(negedge clk) go = 1'b1;
            @(negedge clk) go = 1'b0;
        end
        chk("error_sticky", {61'b0, error, halted, imem_req}, 3'b100);
        reset_dut();
        chk("error_cleared", {63'b0, error}, 0);

`ifdef SEQ_WDOG_EN
        // Watchdog expiry and last-cycle completion.
        fill_mem(16'hF000);
        imem[0]  = 16'h2001;
        alu_hang = 1;
        reset_dut();
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_ALU, 10, "t6_alu", n);
        wait_sig(SIG_ERR, 30, "t6_timeout", n);
        chk("wdog_cycles", n, WDOG + 1);
        alu_hang    = 0;
        dir_alu_dly = WDOG - 1;
        reset_dut();
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_HALT, 40, "t6_done_last", n);
        chk("wdog_late_done", {63'b0, error}, 0);
`else
        // Without the watchdog a slow ALU never causes an error.
        fill_mem(16'hF000);
        imem[0]     = 16'h2001;
        dir_alu_dly = 3 * WDOG;
        reset_dut();
        @(negedge clk) go = 1'b1;
        wait_sig(SIG_HALT, 80, "t6_slow_alu", n);
        chk("no_wdog_error", {63'b0, error}, 0);
`endif

        // Random programs with random latencies and stray inputs.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) imem[i] = rand_instr();
            auto_mode = 1;
            reset_dut();
            fetches = 0;
            hwait   = 0;
            @(negedge clk) go = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                go = 1'b0;
                if (halted) begin
                    if (hwait == 0) go = 1'b1;
                    else hwait--;
                end else begin
                    hwait = int'($urandom_range(0, 3));
                    if ($urandom_range(0, 15) == 0) go = 1'b1;
                end
                if (error || fetches >= 150) break;
            end
            if (error) begin
                repeat (2) @(negedge clk);
                chk("queue_drained", exp_q.size(), 0);
            end
            auto_mode = 0;
        end
        reset_dut();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
